// File: rtl/pwm_cfg_arbiter.sv
// Round-robin sequencer that shares the single div/duty load port of a PWM core among NREQ
// requesters: capture one update at grant, hold it valid until the core's period-end ready, then ack.
module pwm_cfg_arbiter #(
   parameter  int WIDTH = 4,
   parameter  int NREQ  = 4,
   localparam int IDW   = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ-1:0]       req_upd_div,
   input  logic [NREQ-1:0]       req_upd_duty,
   input  logic [NREQ*WIDTH-1:0] req_div,
   input  logic [NREQ*WIDTH-1:0] req_duty,
   output logic [NREQ-1:0]       ack,
   output logic                  cfg_err,
   input  logic                  pwm_ready,
   output logic [WIDTH-1:0]      pwm_div,
   output logic [WIDTH-1:0]      pwm_duty,
   output logic                  pwm_div_valid,
   output logic                  pwm_duty_valid,
   output logic                  busy,
   output logic [IDW-1:0]        owner
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      ACK  = 2'd2
   } state_t;

   state_t state_q, state_nxt;

   // Remembers that the granted request asked for a zero div, reported alongside the ack.
   logic err_flag, err_nxt;

   logic [NREQ-1:0]  ack_nxt;
   logic             cfg_err_nxt;
   logic [WIDTH-1:0] div_nxt, duty_nxt;
   logic             div_valid_nxt, duty_valid_nxt;
   logic             busy_nxt;
   logic [IDW-1:0]   owner_nxt;

   // Round-robin search starting just after the last owner, wrapping modulo NREQ.
   logic [IDW-1:0] grant;
   logic           grant_found;
   logic [IDW-1:0] cand;

   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      grant       = owner;
      grant_found = 1'b0;
      cand        = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = IDW'((int'(owner) + k) % NREQ);
         if (!grant_found && req[cand]) begin
            grant       = cand;
            grant_found = 1'b1;
         end
      end
   end

   logic [WIDTH-1:0] grant_div, grant_duty;
   logic             grant_upd_div, grant_upd_duty;

   assign grant_div      = req_div[int'(grant)*WIDTH +: WIDTH];
   assign grant_duty     = req_duty[int'(grant)*WIDTH +: WIDTH];
   assign grant_upd_div  = req_upd_div[grant];
   assign grant_upd_duty = req_upd_duty[grant];

   always_comb begin
      state_nxt      = state_q;
      owner_nxt      = owner;
      div_nxt        = pwm_div;
      duty_nxt       = pwm_duty;
      div_valid_nxt  = pwm_div_valid;
      duty_valid_nxt = pwm_duty_valid;
      err_nxt        = err_flag;
      ack_nxt        = '0;
      cfg_err_nxt    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (grant_found) begin
               owner_nxt      = grant;
               div_nxt        = grant_div;
               duty_nxt       = grant_duty;
               // A zero divider is never offered to the core; only the duty half survives.
               div_valid_nxt  = grant_upd_div && (grant_div != '0);
               duty_valid_nxt = grant_upd_duty;
               err_nxt        = grant_upd_div && (grant_div == '0);
               if (div_valid_nxt || duty_valid_nxt) begin
                  state_nxt = HOLD;
               end else begin
                  state_nxt      = ACK;
                  ack_nxt[grant] = 1'b1;
                  cfg_err_nxt    = err_nxt;
               end
            end
         end
         HOLD: begin
            if (pwm_ready) begin
               div_valid_nxt  = 1'b0;
               duty_valid_nxt = 1'b0;
               state_nxt      = ACK;
               ack_nxt[owner] = 1'b1;
               cfg_err_nxt    = err_flag;
            end
         end
         ACK: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt      = IDLE;
            div_valid_nxt  = 1'b0;
            duty_valid_nxt = 1'b0;
         end
      endcase

      busy_nxt = (state_nxt != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         owner          <= IDW'(NREQ - 1);
         pwm_div        <= WIDTH'(1);
         pwm_duty       <= '0;
         pwm_div_valid  <= 1'b0;
         pwm_duty_valid <= 1'b0;
         err_flag       <= 1'b0;
         ack            <= '0;
         cfg_err        <= 1'b0;
         busy           <= 1'b0;
      end else begin
         // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
         state_q        <= state_nxt;
         owner          <= owner_nxt;
         pwm_div        <= div_nxt;
         pwm_duty       <= duty_nxt;
         pwm_div_valid  <= div_valid_nxt;
         pwm_duty_valid <= duty_valid_nxt;
         err_flag       <= err_nxt;
         ack            <= ack_nxt;
         cfg_err        <= cfg_err_nxt;
         busy           <= busy_nxt;
      end
   end

endmodule
